// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, pixel colour type and the colour-bar helper.
// The bar helper is used only when VGA_TEST_PATTERN_EN is defined.
package vga_timing_pkg;

    // Default 640x480@60 Hz timing. Horizontal values are pixels; vertical values are lines.
    localparam int unsigned H_VISIBLE_DEF = 640;
    localparam int unsigned H_FRONT_DEF   = 16;
    localparam int unsigned H_SYNC_DEF    = 96;
    localparam int unsigned H_BACK_DEF    = 48;
    localparam int unsigned V_VISIBLE_DEF = 480;
    localparam int unsigned V_FRONT_DEF   = 10;
    localparam int unsigned V_SYNC_DEF    = 2;
    localparam int unsigned V_BACK_DEF    = 33;

    localparam int unsigned H_TOTAL_DEF =
        H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int unsigned V_TOTAL_DEF =
        V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } vga_rgb_t;

    // Eight 80-pixel bars. The bar index bits map to {R,G,B}, so bar 0 is black and bar 7 is white.
    function automatic vga_rgb_t bar_rgb(input logic [9:0] h);
        logic [2:0] bar;
        vga_rgb_t   c;
        bar = 3'(h / 10'd80);
        c.r = {8{bar[2]}};
        c.g = {8{bar[1]}};
        c.b = {8{bar[0]}};
        return c;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a counter that wraps at the axis total, plus active/sync decode.
// wrap is combinational so that it can chain into the next axis in the same cycle.
module vga_axis_counter #(
    parameter int unsigned VISIBLE = 640,
    parameter int unsigned FRONT   = 16,
    parameter int unsigned SYNC    = 96,
    parameter int unsigned BACK    = 48
) (
    input  logic       CLOCK_50_I,
    input  logic       resetn,
    input  logic       count_en,
    output logic [9:0] cnt,
    output logic       wrap,
    output logic       active,
    output logic       sync_n
);

    localparam int unsigned TOTAL    = VISIBLE + FRONT + SYNC + BACK;
    localparam logic [9:0] LAST      = 10'(TOTAL - 1);
    localparam logic [9:0] VIS_END   = 10'(VISIBLE);
    localparam logic [9:0] SYNC_BEG  = 10'(VISIBLE + FRONT);
    localparam logic [9:0] SYNC_END  = 10'(VISIBLE + FRONT + SYNC);  // exclusive

    logic [9:0] cnt_q, cnt_d;

    // Next count: increment on enable and wrap to zero after the last position.
    always_comb begin
        wrap  = count_en && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (wrap) begin
            cnt_d = '0;
        end else if (count_en) begin
            cnt_d = cnt_q + 10'd1;
        end
    end

    // Counter register. Asynchronous reset returns the count to the origin.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt    = cnt_q;
    assign active = (cnt_q < VIS_END);
    assign sync_n = !((cnt_q >= SYNC_BEG) && (cnt_q < SYNC_END));

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator with a registered pixel output stage.
// Define VGA_TEST_PATTERN_EN to replace the iRed/iGreen/iBlue inputs with eight colour bars.
module vga_timing_ctrl
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
    parameter int unsigned H_FRONT   = H_FRONT_DEF,
    parameter int unsigned H_SYNC    = H_SYNC_DEF,
    parameter int unsigned H_BACK    = H_BACK_DEF,
    parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
    parameter int unsigned V_FRONT   = V_FRONT_DEF,
    parameter int unsigned V_SYNC    = V_SYNC_DEF,
    parameter int unsigned V_BACK    = V_BACK_DEF
) (
    input  logic       CLOCK_50_I,
    input  logic       resetn,
    input  logic       enable,
    input  logic [7:0] iRed,
    input  logic [7:0] iGreen,
    input  logic [7:0] iBlue,
    output logic [9:0] oCoord_X,
    output logic [9:0] oCoord_Y,
    output logic       oFrame_start,
    output logic [7:0] oVGA_R,
    output logic [7:0] oVGA_G,
    output logic [7:0] oVGA_B,
    output logic       oVGA_H_SYNC,
    output logic       oVGA_V_SYNC,
    output logic       oVGA_SYNC,
    output logic       oVGA_BLANK
);

    logic [9:0] h_cnt, v_cnt;
    logic       h_wrap, v_wrap;
    logic       h_active, v_active;
    logic       h_sync_n, v_sync_n;
    logic       visible;
    vga_rgb_t   pix_src;

    vga_rgb_t rgb_q, rgb_d;
    logic     hs_q, hs_d;
    logic     vs_q, vs_d;
    logic     blank_q, blank_d;
    logic     fs_q, fs_d;

    vga_axis_counter #(
        .VISIBLE (H_VISIBLE),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK)
    ) u_h_axis (
        .CLOCK_50_I (CLOCK_50_I),
        .resetn     (resetn),
        .count_en   (enable),
        .cnt        (h_cnt),
        .wrap       (h_wrap),
        .active     (h_active),
        .sync_n     (h_sync_n)
    );

    // The line counter advances only when the pixel counter wraps.
    vga_axis_counter #(
        .VISIBLE (V_VISIBLE),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK)
    ) u_v_axis (
        .CLOCK_50_I (CLOCK_50_I),
        .resetn     (resetn),
        .count_en   (h_wrap),
        .cnt        (v_cnt),
        .wrap       (v_wrap),
        .active     (v_active),
        .sync_n     (v_sync_n)
    );

    assign visible = h_active && v_active;

    // Pixel source: the colour bars or the upstream colour for the current coordinate.
    always_comb begin
`ifdef VGA_TEST_PATTERN_EN
        pix_src = bar_rgb(h_cnt);
`else
        pix_src = '{r: iRed, g: iGreen, b: iBlue};
`endif
    end

`ifdef VGA_TEST_PATTERN_EN
    logic unused_rgb_in;
    assign unused_rgb_in = ^{iRed, iGreen, iBlue};
`endif

    // Output stage next state. Values are decoded from the coordinate that is current on this tick.
    always_comb begin
        rgb_d   = rgb_q;
        hs_d    = hs_q;
        vs_d    = vs_q;
        blank_d = blank_q;
        fs_d    = v_wrap;  // v_wrap already implies enable and the h wrap
        if (enable) begin
            rgb_d   = visible ? pix_src : '0;
            blank_d = visible;
            hs_d    = h_sync_n;
            vs_d    = v_sync_n;
        end
    end

    // Output registers. Reset is asynchronous so the DAC is blanked immediately.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            rgb_q   <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            rgb_q   <= rgb_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            blank_q <= blank_d;
            fs_q    <= fs_d;
        end
    end

    assign oCoord_X     = h_cnt;
    assign oCoord_Y     = v_cnt;
    assign oFrame_start = fs_q;
    assign oVGA_R       = rgb_q.r;
    assign oVGA_G       = rgb_q.g;
    assign oVGA_B       = rgb_q.b;
    assign oVGA_H_SYNC  = hs_q;
    assign oVGA_V_SYNC  = vs_q;
    assign oVGA_BLANK   = blank_q;
    assign oVGA_SYNC    = 1'b0;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl. It drives one full-size instance and one instance with a tiny raster,
// so that frame wraps and vertical sync occur within a short run.
module tb_vga_timing_ctrl;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic       rst_n;
    logic       en;
    logic [7:0] ired, igrn, iblu;

    logic [9:0] a_x, a_y, b_x, b_y;
    logic       a_fs, a_hs, a_vs, a_sync, a_blank;
    logic       b_fs, b_hs, b_vs, b_sync, b_blank;
    logic [7:0] a_r, a_g, a_b, b_r, b_g, b_b;

    vga_timing_ctrl dut (
        .CLOCK_50_I   (clk),
        .resetn       (rst_n),
        .enable       (en),
        .iRed         (ired),
        .iGreen       (igrn),
        .iBlue        (iblu),
        .oCoord_X     (a_x),
        .oCoord_Y     (a_y),
        .oFrame_start (a_fs),
        .oVGA_R       (a_r),
        .oVGA_G       (a_g),
        .oVGA_B       (a_b),
        .oVGA_H_SYNC  (a_hs),
        .oVGA_V_SYNC  (a_vs),
        .oVGA_SYNC    (a_sync),
        .oVGA_BLANK   (a_blank)
    );

    // Tiny raster: 15 pixels per line and 8 lines per frame.
    vga_timing_ctrl #(
        .H_VISIBLE (8),
        .H_FRONT   (2),
        .H_SYNC    (3),
        .H_BACK    (2),
        .V_VISIBLE (4),
        .V_FRONT   (1),
        .V_SYNC    (2),
        .V_BACK    (1)
    ) dut_s (
        .CLOCK_50_I   (clk),
        .resetn       (rst_n),
        .enable       (en),
        .iRed         (ired),
        .iGreen       (igrn),
        .iBlue        (iblu),
        .oCoord_X     (b_x),
        .oCoord_Y     (b_y),
        .oFrame_start (b_fs),
        .oVGA_R       (b_r),
        .oVGA_G       (b_g),
        .oVGA_B       (b_b),
        .oVGA_H_SYNC  (b_hs),
        .oVGA_V_SYNC  (b_vs),
        .oVGA_SYNC    (b_sync),
        .oVGA_BLANK   (b_blank)
    );

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       hs;
        logic       vs;
        logic       blank;
    } exp_t;

    localparam exp_t RST = '{r: 8'h00, g: 8'h00, b: 8'h00, hs: 1'b1, vs: 1'b1, blank: 1'b0};

    exp_t qa[$], qb[$];
    exp_t cur_a, cur_b;
    int   ah, av, bh, bv;
    logic fs_a_exp, fs_b_exp;
    int   n_assert = 0;
    int   n_fail = 0;
    int   hs_low_line0 = 0;
    int   red_line0 = 0;
    int   fs_count = 0;
    int   last_tick_h;
    logic [7:0] last_r, last_g, last_b;

    // Reference output for one tick at (h, v), derived directly from the timing definition.
    function automatic exp_t model_out(input int h, input int v, input int hv, input int hf,
                                       input int hsw, input int vv, input int vf, input int vsw,
                                       input logic [7:0] r, input logic [7:0] g,
                                       input logic [7:0] b);
        exp_t e;
        logic vis;
        logic [7:0] pr, pg, pb;
        int idx;
        vis = (h < hv) && (v < vv);
`ifdef VGA_TEST_PATTERN_EN
        idx = h / 80;
        pr = idx[2] ? 8'hFF : 8'h00;
        pg = idx[1] ? 8'hFF : 8'h00;
        pb = idx[0] ? 8'hFF : 8'h00;
`else
        idx = 0;
        pr = r;
        pg = g;
        pb = b;
`endif
        e.r     = vis ? pr : 8'h00;
        e.g     = vis ? pg : 8'h00;
        e.b     = vis ? pb : 8'h00;
        e.hs    = !((h >= hv + hf) && (h < hv + hf + hsw));
        e.vs    = !((v >= vv + vf) && (v < vv + vf + vsw));
        e.blank = vis;
        return e;
    endfunction

    function automatic logic [63:0] pk(input int x, input int y, input logic fs, input exp_t e);
        return {15'd0, 10'(x), 10'(y), fs, e, 1'b0};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_outputs();
        check("dut_a", {15'd0, a_x, a_y, a_fs, a_r, a_g, a_b, a_hs, a_vs, a_blank, a_sync},
              pk(ah, av, fs_a_exp, cur_a));
        check("dut_s", {15'd0, b_x, b_y, b_fs, b_r, b_g, b_b, b_hs, b_vs, b_blank, b_sync},
              pk(bh, bv, fs_b_exp, cur_b));
    endtask

    // One clock. The bench drives at the negedge, the DUT reacts at the posedge, and the bench checks at the next negedge.
    task automatic step(input logic e);
        int tick_v;
        en = e;
`ifdef VGA_TEST_PATTERN_EN
        ired = 8'hAA;
        igrn = 8'hAA;
        iblu = 8'hAA;
`else
        ired = ((ah >= 100) && (ah <= 139) && (av <= 1)) ? 8'hFF : 8'h00;
        igrn = 8'hFF;
        iblu = 8'($urandom);
`endif
        fs_a_exp = 1'b0;
        fs_b_exp = 1'b0;
        tick_v = -1;
        if (e) begin
            qa.push_back(model_out(ah, av, 640, 16, 96, 480, 10, 2, ired, igrn, iblu));
            qb.push_back(model_out(bh, bv, 8, 2, 3, 4, 1, 2, ired, igrn, iblu));
            last_tick_h = ah;
            tick_v = av;
            last_r = ired;
            last_g = igrn;
            last_b = iblu;
            fs_a_exp = (ah == 799) && (av == 524);
            fs_b_exp = (bh == 14) && (bv == 7);
            if (ah == 799) begin
                ah = 0;
                av = (av == 524) ? 0 : av + 1;
            end else begin
                ah++;
            end
            if (bh == 14) begin
                bh = 0;
                bv = (bv == 7) ? 0 : bv + 1;
            end else begin
                bh++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (e) begin
            cur_a = qa.pop_front();
            cur_b = qb.pop_front();
        end
        check_outputs();
        if (tick_v == 0) begin
            if (!a_hs) hs_low_line0++;
            if (a_r == 8'hFF) red_line0++;
        end
        if (b_fs) fs_count++;
    endtask

    task automatic reset_model();
        qa.delete();
        qb.delete();
        ah = 0; av = 0; bh = 0; bv = 0;
        cur_a = RST;
        cur_b = RST;
        fs_a_exp = 1'b0;
        fs_b_exp = 1'b0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        en = 1'b0;
        ired = 8'h00;
        igrn = 8'h00;
        iblu = 8'h00;
        last_tick_h = -1;
        reset_model();

        // The outputs hold their reset state while reset is asserted.
        #25;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs();

        // Two full lines with a toggling strobe. The tiny instance completes 13 frames in this time.
        for (int i = 0; i < 1600; i++) begin
            step(1'b1);
            step(1'b0);
        end
        check("hsync_low_ticks", 64'(hs_low_line0), 64'd96);
`ifdef VGA_TEST_PATTERN_EN
        check("red_ticks_line0", 64'(red_line0), 64'd320);
`else
        check("red_ticks_line0", 64'(red_line0), 64'd40);
`endif
        check("frame_pulses", 64'(fs_count), 64'd13);
        check("line2_y", 64'(a_y), 64'd2);

        // Stall at h=10 for 50 clocks, then resume.
        for (int i = 0; i < 10; i++) begin
            step(1'b1);
            step(1'b0);
        end
        for (int i = 0; i < 50; i++) step(1'b0);
        step(1'b1);
        check("resume_x", 64'(a_x), 64'd11);

        // Continuous enable at the full clock rate, up to h=300.
        for (int i = 0; i < 289; i++) step(1'b1);
        check("pre_reset_x", 64'(a_x), 64'd300);

        // Asynchronous reset in the middle of a line.
        en = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        reset_model();
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Colour at bar starts and in the blanked region of line 0.
        for (int i = 0; i < 720; i++) begin
            step(1'b1);
            if (last_tick_h == 0 || last_tick_h == 80 || last_tick_h == 560 ||
                last_tick_h == 700) begin
`ifdef VGA_TEST_PATTERN_EN
                check("bar_rgb", {40'd0, a_r, a_g, a_b},
                      (last_tick_h == 80)  ? 64'h0000FF :
                      (last_tick_h == 560) ? 64'hFFFFFF : 64'h000000);
`else
                check("pass_rgb", {40'd0, a_r, a_g, a_b},
                      (last_tick_h == 700) ? 64'h000000 : {40'd0, last_r, last_g, last_b});
`endif
            end
            step(1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
- 640x480@60 Hz VGA raster timing generator and pixel output register stage.
- Sits directly upstream of the board VGA DAC and drives the `pixel_X/Y` coordinates consumed by the object/colour logic.
- Samples that logic's RGB result and emits registered RGB, HSYNC, VSYNC, BLANK and SYNC.
- Runs on CLOCK_50_I and advances only on the 25 MHz `enable` strobe.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)

Ports:
- clock  in  1  CLOCK_50_I, 50 MHz
- resetn  in  1  asynchronous, active-low reset
- enable  in  1  pixel strobe; high every other clock
- iRed / iGreen / iBlue  in  8 each  colour for current coordinate
- oCoord_X  out  10  horizontal counter value, 0..H_TOTAL-1
- oCoord_Y  out  10  vertical counter value, 0..V_TOTAL-1
- oFrame_start  out  1  one-clock pulse at frame wrap
- oVGA_R / oVGA_G / oVGA_B  out  8 each  registered colour
- oVGA_H_SYNC  out  1  active-low horizontal sync
- oVGA_V_SYNC  out  1  active-low vertical sync
- oVGA_SYNC  out  1  composite sync, tied 0
- oVGA_BLANK  out  1  active-low blank; 1 inside the visible region

Behaviour:
- **Interface:** reset is resetn, asynchronous, active-low; clock is CLOCK_50_I. All flops use posedge clock / negedge resetn.
- **Derived widths:** H_TOTAL = sum of the four H parameters (800); V_TOTAL = sum of the four V parameters (525).
- **Reset values:** h_cnt = 0, v_cnt = 0, RGB = 0, H_SYNC = 1, V_SYNC = 1, BLANK = 0, oFrame_start = 0, oVGA_SYNC = 0.
- **Counting:**
  - On a clock edge with enable = 1, h_cnt increments.
  - At H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - At v_cnt = V_TOTAL-1 together with the h wrap, v_cnt wraps to 0.
  - With enable = 0, all state and outputs hold.
- **Coordinates:** oCoord_X = h_cnt and oCoord_Y = v_cnt, driven directly from the registers with no added latency.
- **Output stage:** on each enable edge, outputs register values decoded from the *current* (h_cnt, v_cnt), concurrently with the counter increment. Output latency is therefore 1 enable tick (2 clocks) after the coordinate is presented.
  - visible = h_cnt < H_VISIBLE && v_cnt < V_VISIBLE.
  - RGB <= visible ? iRGB : 0.
  - BLANK <= visible.
  - H_SYNC <= !(h_cnt in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1]), i.e. low for 656..751.
  - V_SYNC <= !(v_cnt in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1]), i.e. low for lines 490..491 over every h_cnt.
- **oFrame_start:** high for exactly one clock, on the clock after the enable edge where (h_cnt, v_cnt) wraps from (799, 524) to (0, 0). It is not asserted after reset release.
- **Input timing:** iRGB is sampled only on enable edges; combinational upstream logic has a full 2-clock window.
- **Boundary conditions:**
  - Reset mid-line or mid-frame returns to (0, 0) immediately; outputs return to their reset values asynchronously.
  - enable held high continuously runs at 50 MHz; this is legal, only the timing doubles in speed.
- **Arithmetic:** unsigned 10-bit throughout; no counter ever exceeds TOTAL-1.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- Defined: iRed/iGreen/iBlue are ignored. The visible region shows 8 vertical bars of 80 pixels each. Bar index = h_cnt[9:0] / 80, with colour bits {R,G,B} = index[2:0] each expanded to 8'hFF/8'h00. Order: bar 0 black ... bar 7 white (pure binary mapping).
- Undefined: pass-through behaviour as above.
- Sync and blank timing are identical in both builds.

Decomposition:
- **Package `vga_timing_pkg`:** default timing constants (640/16/96/48, 480/10/2/33), derived H_TOTAL/V_TOTAL, and a typedef `vga_rgb_t` (struct of three 8-bit channels).
- **Sub-module `vga_axis_counter`:** instantiated twice.
  - Parameters: VISIBLE, FRONT, SYNC, BACK.
  - Inputs: clock, resetn, count_en.
  - Outputs: cnt, wrap (combinational: count_en && cnt == TOTAL-1), active, sync_n.
  - The horizontal instance's wrap drives the vertical instance's count_en.

Test Plan:
- **Reset and hold:** assert resetn = 0 mid-frame at (h=300, v=200) -> same cycle all outputs reach their reset values; coords read (0, 0); BLANK = 0, H_SYNC = 1.
- **Line timing:** release reset, toggle enable -> oCoord_X reaches 799 after 1598 clocks, then 0 with oCoord_Y = 1. H_SYNC is low for exactly 96 enable ticks, starting on the enable edge where oCoord_X = 656.
- **Frame timing:** run 840000 clocks -> V_SYNC is low for 2 × 800 enable ticks starting at v = 490. oFrame_start pulses once per 840000 clocks, one clock wide.
- **Colour latency and blanking:** drive iRed = 8'hFF only when oCoord_X in [100, 139] and oCoord_Y in [220, 259] -> oVGA_R = 8'hFF for 40 ticks per line, delayed 1 enable tick. RGB = 0 whenever h ≥ 640, even with iRGB = 8'hFF.
- **Enable stall:** hold enable = 0 for 50 clocks at (h=10, v=5) -> coords and all outputs frozen; resuming continues from h = 11.
- **VGA_TEST_PATTERN_EN build:** at v = 0, h = 0, 80, 560 -> RGB = 000000, 0000FF, FFFFFF respectively, with inputs tied to 8'hAA.
